alu_digit_serial: RTL and testbench
===================================

// Module: alu_digit_serial
// PURPOSE
//  Multi-cycle, width-parametrised ALU that processes operands one 4-bit digit per clock, LSB digit first.
//  Supports native binary and decimal (BCD) add/subtract, with per-digit decimal correction.
//  Serves as the datapath ALU for the wide-word core.
//  Uses a start/busy/done handshake; results and flags are registered and held until the next operation completes.
// PARAMETERS
//  WIDTH   16  operand/result width in bits; multiple of 4, >= 8
//  DIGITS  WIDTH/4  derived (localparam); number of digit cycles per operation
// PORTS
//  clk      in   1      single clock; all state changes on rising edge
//  reset_n  in   1      asynchronous, active-low reset
//  start    in   1      request; sampled only when busy=0
//  op       in   3      ALU_* operation code: AI, ADC, ROL, ROR, ORA, EOR, AND
//  dec      in   1      decimal mode; applies to ALU_ADC only
//  mem_bi   in   1      BI = MI when 1, else all-zero
//  inv_bi   in   1      invert BI; with dec=1 selects decimal subtract
//  AI       in   WIDTH  A operand
//  MI       in   WIDTH  memory operand
//  CI       in   1      carry in
//  busy     out  1      operation in progress
//  done     out  1      one-cycle pulse: OUT and flags updated
//  OUT      out  WIDTH  result (registered)
//  C,N,Z,V  out  1 each registered flags
//  HC       out  1      binary carry out of digit 0
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; busy=0, done=0, OUT=0, C=N=Z=V=HC=0; any operation in flight is aborted, no done.
//  Start: in IDLE with start=1, latch AI, BI=({W{mem_bi}}&MI)^{W{inv_bi}}, CI, op, dec; digit counter=0; busy=1.
//    start is ignored while busy=1.
//  FSM: IDLE -> RUN on start; RUN steps one digit per cycle; after digit DIGITS-1, RUN -> IDLE.
//    Results/flags are registered on that final edge, and done=1 for exactly the following cycle.
//    Latency: done asserts DIGITS cycles after the start edge, for every op.
//    Back-to-back: start may be asserted in the same cycle as done.
//  Per digit (ALU_ADC):
//    s = a + b + c, a 5-bit binary sum; c = carry from the previous digit (CI for digit 0).
//    dec=0: digit = s[3:0], carry = s[4].
//    dec=1, inv_bi=0: if s>9 then digit=(s+6)[3:0], carry=1; else digit=s[3:0], carry=0.
//    dec=1, inv_bi=1: if s[4]=0 then digit=(s-6)[3:0], carry=0; else digit=s[3:0], carry=1.
//  Logic ops (ORA/EOR/AND/AI) are evaluated per digit; carry chain still runs in binary for C.
//  ROL/ROR: word-wide shift of latched AI with CI; C = AI[WIDTH-1] (ROL) or AI[0] (ROR).
//  Undefined op: OUT = {DIGITS{4'h5}}, C = binary carry chain.
//  Flags at done:
//    N = OUT[WIDTH-1]; Z = (OUT==0).
//    V = binary carry into bit WIDTH-1 XOR binary carry out of bit WIDTH-1 (never decimal-adjusted).
//    C = final (decimal-adjusted when dec=1, op=ADC) digit carry.
//    HC = binary carry out of bit 3.
//  dec with an op other than ALU_ADC: ignored (binary behaviour).
// STRUCTURE
//  Shared include/package: ALU_* op-code constants, FSM state encodings (IDLE, RUN).
//  Sub-module alu_digit: combinational 4-bit slice (a, b, c, dec, inv, op) -> (digit, carry, binary carry, carry-into-bit3).
//  Top level: FSM, digit counter, operand shift registers, result shift register, flag registers.
// TESTING (WIDTH=16)
//  1. ADC dec=0: AI=7FFF, MI=0001, CI=0 -> OUT=8000, N=1, V=1, C=0, Z=0; done exactly 4 cycles after start.
//  2. ADC dec=1: AI=0999, MI=0001, CI=0 -> OUT=1000, C=0, HC=0.
//  3. ADC dec=1, inv_bi=1 (subtract): AI=1000, MI=0001, CI=1 -> OUT=0999, C=1; AI=0000, MI=0001 -> OUT=9999, C=0.
//  4. ROL: AI=8001, CI=1 -> OUT=0003, C=1. ROR: AI=8001, CI=0 -> OUT=4000, C=1.
//  5. Handshake: start held during busy is ignored. Start in the done cycle -> second done 4 cycles later.
//     mem_bi=0, inv_bi=0, CI=1 on AI=FFFF -> OUT=0000, Z=1, C=1.
//  6. Reset: reset_n low mid-RUN (after 2 digits) -> busy=0, all outputs 0 immediately; no done pulse.
//     Next start completes normally.

Source files
------------

// File: rtl/alu_digit_serial_pkg.sv
// Shared definitions for the digit-serial ALU: op codes, FSM states, flag payload.
package alu_digit_serial_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [2:0] {
        ALU_ORA = 3'd0,
        ALU_AND = 3'd1,
        ALU_EOR = 3'd2,
        ALU_ADC = 3'd3,
        ALU_AI  = 3'd4,
        ALU_ROL = 3'd5,
        ALU_ROR = 3'd6
    } alu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic c;
        logic n;
        logic z;
        logic v;
        logic hc;
    } alu_flags_t;

endpackage

// File: rtl/alu_digit_serial_if.sv
// Request/result bundle between the core and the digit-serial ALU.
interface alu_digit_serial_if
    import alu_digit_serial_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) ();

    logic             start;
    alu_op_e          op;
    logic             dec;
    logic             mem_bi;
    logic             inv_bi;
    logic [WIDTH-1:0] AI;
    logic [WIDTH-1:0] MI;
    logic             CI;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] OUT;
    logic             C;
    logic             N;
    logic             Z;
    logic             V;
    logic             HC;

    modport master (
        output start, op, dec, mem_bi, inv_bi, AI, MI, CI,
        input  busy, done, OUT, C, N, Z, V, HC
    );

    modport slave (
        input  start, op, dec, mem_bi, inv_bi, AI, MI, CI,
        output busy, done, OUT, C, N, Z, V, HC
    );

endinterface

// File: rtl/alu_digit_serial_digit.sv
// Combinational 4-bit ALU slice: one digit of result plus chain carry,
// raw binary carry out and carry into bit 3 (for overflow on the top digit).
module alu_digit_serial_digit
    import alu_digit_serial_pkg::*;
(
    input  logic [DIGIT_W-1:0] a_i,
    input  logic [DIGIT_W-1:0] b_i,
    input  logic               c_i,
    input  logic               nxt_i,
    input  logic               dec_i,
    input  logic               inv_i,
    input  alu_op_e            op_i,
    output logic [DIGIT_W-1:0] digit_o,
    output logic               carry_o,
    output logic               bin_carry_o,
    output logic               c3_o
);

    logic [DIGIT_W:0]   sum;
    logic [DIGIT_W-1:0] low3;

    always_comb begin
        sum         = 5'(a_i) + 5'(b_i) + 5'(c_i);
        low3        = 4'(a_i[2:0]) + 4'(b_i[2:0]) + 4'(c_i);
        bin_carry_o = sum[DIGIT_W];
        c3_o        = low3[3];
        digit_o     = 4'h5;
        carry_o     = sum[DIGIT_W];

        case (op_i)
            ALU_ADC: begin
                if (dec_i && !inv_i) begin
                    // BCD add: fold sums above 9 back into 0..9 with a carry
                    if (sum > 5'd9) begin
                        digit_o = 4'(sum + 5'd6);
                        carry_o = 1'b1;
                    end else begin
                        digit_o = sum[3:0];
                        carry_o = 1'b0;
                    end
                end else if (dec_i) begin
                    // BCD subtract: a missing carry means a borrow, remove the 6 skipped codes
                    if (!sum[DIGIT_W]) begin
                        digit_o = 4'(sum - 5'd6);
                        carry_o = 1'b0;
                    end else begin
                        digit_o = sum[3:0];
                        carry_o = 1'b1;
                    end
                end else begin
                    digit_o = sum[3:0];
                end
            end
            ALU_ORA: digit_o = a_i | b_i;
            ALU_AND: digit_o = a_i & b_i;
            ALU_EOR: digit_o = a_i ^ b_i;
            ALU_AI:  digit_o = a_i;
            ALU_ROL: begin
                digit_o = {a_i[2:0], c_i};
                carry_o = a_i[3];
            end
            ALU_ROR: begin
                // chain carry holds AI[0] unchanged through to the last digit
                digit_o = {nxt_i, a_i[3:1]};
                carry_o = c_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_digit_serial.sv
// Digit-serial ALU: one 4-bit digit per clock, LSB first, start/busy/done handshake.
module alu_digit_serial
    import alu_digit_serial_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    alu_digit_serial_if.slave  bus
);

    localparam int unsigned DIGITS = WIDTH / DIGIT_W;
    localparam int unsigned CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned RES_W  = WIDTH - DIGIT_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic [RES_W-1:0] res_q,   res_d;
    logic             c_q,     c_d;
    logic             ci_q,    ci_d;
    logic             hc_q,    hc_d;
    alu_op_e          op_q,    op_d;
    logic             dec_q,   dec_d;
    logic             inv_q,   inv_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic [WIDTH-1:0] out_q,   out_d;
    alu_flags_t       flags_q, flags_d;

    logic [DIGIT_W-1:0] digit;
    logic               carry;
    logic               bin_carry;
    logic               c3;
    logic               last;
    logic               nxt;

    assign last = (cnt_q == LAST);
    // ROR needs bit 0 of the next-higher digit; CI enters at the top
    assign nxt  = last ? ci_q : a_q[DIGIT_W];

    alu_digit_serial_digit u_digit (
        .a_i         (a_q[DIGIT_W-1:0]),
        .b_i         (b_q[DIGIT_W-1:0]),
        .c_i         (c_q),
        .nxt_i       (nxt),
        .dec_i       (dec_q),
        .inv_i       (inv_q),
        .op_i        (op_q),
        .digit_o     (digit),
        .carry_o     (carry),
        .bin_carry_o (bin_carry),
        .c3_o        (c3)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        c_d     = c_q;
        ci_d    = ci_q;
        hc_d    = hc_q;
        op_d    = op_q;
        dec_d   = dec_q;
        inv_d   = inv_q;
        done_d  = 1'b0;
        out_d   = out_q;
        flags_d = flags_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    a_d     = bus.AI;
                    b_d     = ({WIDTH{bus.mem_bi}} & bus.MI) ^ {WIDTH{bus.inv_bi}};
                    c_d     = (bus.op == ALU_ROR) ? bus.AI[0] : bus.CI;
                    ci_d    = bus.CI;
                    op_d    = bus.op;
                    dec_d   = bus.dec && (bus.op == ALU_ADC);
                    inv_d   = bus.inv_bi;
                end
            end
            RUN: begin
                a_d   = a_q >> DIGIT_W;
                b_d   = b_q >> DIGIT_W;
                c_d   = carry;
                res_d = RES_W'({digit, res_q} >> DIGIT_W);
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == '0) begin
                    hc_d = bin_carry;
                end
                if (last) begin
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    out_d       = {digit, res_q};
                    flags_d.c   = carry;
                    flags_d.n   = digit[DIGIT_W-1];
                    flags_d.z   = ({digit, res_q} == '0);
                    flags_d.v   = c3 ^ bin_carry;
                    flags_d.hc  = hc_q;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            ci_q    <= 1'b0;
            hc_q    <= 1'b0;
            op_q    <= ALU_ORA;
            dec_q   <= 1'b0;
            inv_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            c_q     <= c_d;
            ci_q    <= ci_d;
            hc_q    <= hc_d;
            op_q    <= op_d;
            dec_q   <= dec_d;
            inv_q   <= inv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
            flags_q <= flags_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.OUT  = out_q;
    assign bus.C    = flags_q.c;
    assign bus.N    = flags_q.n;
    assign bus.Z    = flags_q.z;
    assign bus.V    = flags_q.v;
    assign bus.HC   = flags_q.hc;

endmodule

// File: tb/tb_alu_digit_serial.sv
// Directed bench for alu_digit_serial at WIDTH=16 with hand-computed expectations.
module tb_alu_digit_serial;
    import alu_digit_serial_pkg::*;

    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    alu_digit_serial_if #(.WIDTH(W)) bus ();

    alu_digit_serial #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int lat;
    logic seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input alu_op_e op, input logic dec, input logic mem, input logic inv,
                         input logic [W-1:0] ai, input logic [W-1:0] mi, input logic ci);
        bus.op     = op;
        bus.dec    = dec;
        bus.mem_bi = mem;
        bus.inv_bi = inv;
        bus.AI     = ai;
        bus.MI     = mi;
        bus.CI     = ci;
        bus.start  = 1'b1;
    endtask

    // Called #1 after an edge with start already driven; returns edges from start edge to done.
    task automatic wait_done(output int cyc);
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (bus.done !== 1'b1 && cyc < 20);
    endtask

    task automatic run(input string tag, input alu_op_e op, input logic dec, input logic mem,
                       input logic inv, input logic [W-1:0] ai, input logic [W-1:0] mi, input logic ci);
        drive(op, dec, mem, inv, ai, mi, ci);
        wait_done(lat);
        check({tag, "_latency"}, lat, 4);
    endtask

    task automatic res_cnz(input string tag, input logic [W-1:0] out, input logic c,
                           input logic n, input logic z);
        check({tag, "_OUT"}, bus.OUT, out);
        check({tag, "_C"}, bus.C, c);
        check({tag, "_N"}, bus.N, n);
        check({tag, "_Z"}, bus.Z, z);
    endtask

    task automatic res_vh(input string tag, input logic v, input logic hc);
        check({tag, "_V"}, bus.V, v);
        check({tag, "_HC"}, bus.HC, hc);
    endtask

    initial begin
        reset_n    = 1'b0;
        bus.start  = 1'b0;
        bus.op     = ALU_ADC;
        bus.dec    = 1'b0;
        bus.mem_bi = 1'b0;
        bus.inv_bi = 1'b0;
        bus.AI     = '0;
        bus.MI     = '0;
        bus.CI     = 1'b0;
        #12;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_OUT", bus.OUT, 0);
        check("rst_flags", {bus.C, bus.N, bus.Z, bus.V, bus.HC}, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // binary add with signed overflow
        run("adc_bin", ALU_ADC, 1'b0, 1'b1, 1'b0, 16'h7FFF, 16'h0001, 1'b0);
        res_cnz("adc_bin", 16'h8000, 1'b0, 1'b1, 1'b0);
        res_vh("adc_bin", 1'b1, 1'b1);
        @(posedge clk); #1;
        check("done_pulse_width", bus.done, 0);
        check("idle_busy", bus.busy, 0);

        run("adc_dec", ALU_ADC, 1'b1, 1'b1, 1'b0, 16'h0999, 16'h0001, 1'b0);
        res_cnz("adc_dec", 16'h1000, 1'b0, 1'b0, 1'b0);
        res_vh("adc_dec", 1'b0, 1'b0);

        run("sub_dec1", ALU_ADC, 1'b1, 1'b1, 1'b1, 16'h1000, 16'h0001, 1'b1);
        res_cnz("sub_dec1", 16'h0999, 1'b1, 1'b0, 1'b0);
        res_vh("sub_dec1", 1'b0, 1'b0);

        run("sub_dec2", ALU_ADC, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0001, 1'b1);
        res_cnz("sub_dec2", 16'h9999, 1'b0, 1'b1, 1'b0);

        run("rol", ALU_ROL, 1'b0, 1'b0, 1'b0, 16'h8001, 16'h0000, 1'b1);
        res_cnz("rol", 16'h0003, 1'b1, 1'b0, 1'b0);

        run("ror", ALU_ROR, 1'b0, 1'b0, 1'b0, 16'h8001, 16'h0000, 1'b0);
        res_cnz("ror", 16'h4000, 1'b1, 1'b0, 1'b0);

        // logic ops: C still from the binary sum F0F0+3C3C = 1_2D2C
        run("ora", ALU_ORA, 1'b0, 1'b1, 1'b0, 16'hF0F0, 16'h3C3C, 1'b0);
        res_cnz("ora", 16'hFCFC, 1'b1, 1'b1, 1'b0);
        run("and", ALU_AND, 1'b0, 1'b1, 1'b0, 16'hF0F0, 16'h3C3C, 1'b0);
        res_cnz("and", 16'h3030, 1'b1, 1'b0, 1'b0);
        run("eor", ALU_EOR, 1'b0, 1'b1, 1'b0, 16'hF0F0, 16'h3C3C, 1'b0);
        res_cnz("eor", 16'hCCCC, 1'b1, 1'b1, 1'b0);
        run("ora_dec", ALU_ORA, 1'b1, 1'b1, 1'b0, 16'hF0F0, 16'h3C3C, 1'b0);
        res_cnz("ora_dec", 16'hFCFC, 1'b1, 1'b1, 1'b0);
        run("pass_ai", ALU_AI, 1'b0, 1'b1, 1'b0, 16'hF0F0, 16'h3C3C, 1'b0);
        res_cnz("pass_ai", 16'hF0F0, 1'b1, 1'b1, 1'b0);

        run("undef", alu_op_e'(3'd7), 1'b0, 1'b1, 1'b0, 16'h8000, 16'h8000, 1'b0);
        res_cnz("undef", 16'h5555, 1'b1, 1'b0, 1'b0);

        // start held high while busy must not restart or corrupt the operation
        @(posedge clk); #1;
        drive(ALU_ADC, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h1111, 1'b0);
        @(posedge clk); #1;
        bus.AI = 16'h0000;
        bus.MI = 16'h0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 2;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (bus.done !== 1'b1 && lat < 20);
        check("held_latency", lat, 4);
        res_cnz("held", 16'h2345, 1'b0, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            seen |= bus.done;
        end
        check("held_no_extra_done", seen, 0);

        // back-to-back: second start in the done cycle
        run("b2b_a", ALU_ADC, 1'b1, 1'b1, 1'b0, 16'h0055, 16'h0045, 1'b0);
        res_cnz("b2b_a", 16'h0100, 1'b0, 1'b0, 1'b0);
        run("b2b_b", ALU_ADC, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h1234, 1'b1);
        res_cnz("b2b_b", 16'h0000, 1'b1, 1'b0, 1'b1);
        res_vh("b2b_b", 1'b0, 1'b1);

        // async reset after two digits aborts the operation
        @(posedge clk); #1;
        drive(ALU_ADC, 1'b0, 1'b1, 1'b0, 16'h7FFF, 16'h0001, 1'b0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_OUT", bus.OUT, 0);
        check("abort_flags", {bus.C, bus.N, bus.Z, bus.V, bus.HC}, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            seen |= bus.done | bus.busy;
        end
        check("abort_no_done", seen, 0);

        run("post_rst", ALU_ADC, 1'b1, 1'b1, 1'b0, 16'h0999, 16'h0001, 1'b0);
        res_cnz("post_rst", 16'h1000, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
